// File: rtl/marker_pixel_streamer.sv
// marker_pixel_streamer: colour-threshold pixel matcher with run-length filter, emitting coordinates for the corner FSM
// Ports:
//   clk, reset                  clock (one pixel per cycle), synchronous active-high reset
//   VGA_VS, VGA_BLANK_N         video timing (VS active low, BLANK_N high in active video)
//   color_r/g/b                 current pixel colour
//   r_min, g_max, b_max         match thresholds (r >= r_min, g <= g_max, b <= b_max)
//   run_len                     consecutive matches needed before a pixel is emitted
//   pixel_x, pixel_y, pixel_valid   filtered pixel, two cycles after it was presented
//   VGA_VS_out                  VGA_VS delayed to stay aligned with the pixel outputs
//   match_count, frame_done     valid-pixel count of the last frame and its update strobe
module marker_pixel_streamer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int RUN_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             VGA_VS,
    input  logic             VGA_BLANK_N,
    input  logic [7:0]       color_r,
    input  logic [7:0]       color_g,
    input  logic [7:0]       color_b,
    input  logic [7:0]       r_min,
    input  logic [7:0]       g_max,
    input  logic [7:0]       b_max,
    input  logic [RUN_W-1:0] run_len,
    output logic [9:0]       pixel_x,
    output logic [9:0]       pixel_y,
    output logic             pixel_valid,
    output logic             VGA_VS_out,
    output logic [18:0]      match_count,
    output logic             frame_done
);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {S_WAIT_SYNC, S_HBLANK, S_LINE} state_t;

    state_t           state, state_nx;
    logic [9:0]       x_cnt, y_cnt, x_nx, y_nx, cur_x;
    logic             y_over, y_over_nx;
    logic             vs_d1, vs_d2, vs_fall, out_fall, active, over, match;
    logic [9:0]       s1_x, s1_y;
    logic             s1_match;
    logic [RUN_W-1:0] run;
    logic [RUN_W:0]   run_inc;
    logic             valid;
    logic [18:0]      acc;

    // x_cnt holds the coordinate of the previous pixel of the line; y_over marks lines past the last one
    always_comb begin
        vs_fall   = vs_d1 & ~VGA_VS;
        active    = VGA_BLANK_N & ~vs_fall & (state != S_WAIT_SYNC);
        cur_x     = (state == S_LINE) ? ((x_cnt == X_MAX) ? x_cnt : x_cnt + 10'd1) : '0;
        over      = y_over | (state == S_LINE && x_cnt == X_MAX);
        match     = active & ~over & (color_r >= r_min) & (color_g <= g_max) & (color_b <= b_max);
        state_nx  = state;
        x_nx      = x_cnt;
        y_nx      = y_cnt;
        y_over_nx = y_over;
        if (vs_fall) begin
            state_nx  = S_HBLANK;
            x_nx      = '0;
            y_nx      = '0;
            y_over_nx = 1'b0;
        end else if (state == S_HBLANK && VGA_BLANK_N) begin
            state_nx = S_LINE;
            x_nx     = '0;
        end else if (state == S_LINE) begin
            if (VGA_BLANK_N) begin
                x_nx = cur_x;
            end else begin
                state_nx  = S_HBLANK;
                y_nx      = (y_cnt == Y_MAX) ? y_cnt : y_cnt + 10'd1;
                y_over_nx = y_over | (y_cnt == Y_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_WAIT_SYNC;
            x_cnt  <= '0;
            y_cnt  <= '0;
            y_over <= 1'b0;
        end else begin
            state  <= state_nx;
            x_cnt  <= x_nx;
            y_cnt  <= y_nx;
            y_over <= y_over_nx;
        end
    end

    // Run filter: non-matching pixels (including blanking and the VS-edge cycle) clear the run
    always_comb begin
        run_inc  = {1'b0, run} + 1'b1;
        valid    = s1_match & (run_inc >= {1'b0, run_len});
        out_fall = vs_d2 & ~vs_d1;
    end

    assign VGA_VS_out = vs_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_x        <= '0;
            s1_y        <= '0;
            s1_match    <= 1'b0;
            run         <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
            vs_d1       <= 1'b1;
            vs_d2       <= 1'b1;
            acc         <= '0;
            match_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            s1_x        <= cur_x;
            s1_y        <= y_cnt;
            s1_match    <= match;
            run         <= s1_match ? (run_inc[RUN_W] ? run : run_inc[RUN_W-1:0]) : '0;
            pixel_valid <= valid;
            if (valid) begin
                pixel_x <= s1_x;
                pixel_y <= s1_y;
            end
            vs_d1       <= VGA_VS;
            vs_d2       <= vs_d1;
            // a pixel going valid on the frame boundary belongs to the new frame
            acc         <= out_fall ? 19'(valid) : acc + 19'(valid);
            frame_done  <= out_fall;
            if (out_fall)
                match_count <= acc;
        end
    end
endmodule
